btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//   Conditions a raw, asynchronous push-button into clean one-cycle press events.
//   Synchronises the input, debounces press and release, and emits auto-repeat pulses on a long hold.
//   Sits directly upstream of the counter/seven-segment top: o_pulse drives its i_btn,
//   so each physical press advances the digit exactly once.
// PARAMETERS
//   SYNC_STAGES      2       synchroniser flop depth (>=2)
//   DEBOUNCE_CYCLES  10000   consecutive stable synced samples needed to accept a press or a release (>=1)
//   REPEAT_EN        1       1: emit auto-repeat pulses while held; 0: o_held only, no repeat pulses
//   REPEAT_DELAY     500000  cycles in the accepted-press state before the first repeat (>=1)
//   REPEAT_PERIOD    100000  cycles between subsequent repeat pulses (>=1)
//   Internal counter widths come from $clog2 of the largest parameter; no wrap inside a valid range.
// PORTS
//   i_clk    in   1  system clock
//   i_reset  in   1  asynchronous, active-high reset
//   i_btn    in   1  raw button, asynchronous to i_clk, may bounce
//   o_pulse  out  1  one-cycle strobe: accepted press, and each auto-repeat
//   o_level  out  1  debounced button level
//   o_held   out  1  high from the first repeat point until the release is accepted
// BEHAVIOUR
//   Reset (async assert, sync-safe deassert by design of the user):
//   - state IDLE; all counters, synchroniser flops and outputs are 0, immediately with no clock edge.
//   - A button held through reset is seen as a new press after reset.
//   Synchroniser: s = i_btn after SYNC_STAGES flops. Only s is used downstream.
//   FSM (all outputs registered):
//   - IDLE: o_level=0. s=1 -> PRESS_WAIT, deb_cnt=1.
//   - PRESS_WAIT: s=0 -> IDLE, count discarded. s=1 -> deb_cnt++.
//     On the DEBOUNCE_CYCLES-th consecutive high sample -> PRESSED; o_level=1; o_pulse=1 next cycle.
//     rep_cnt=0, rep_phase=0.
//   - PRESSED: s=1 -> rep_cnt++.
//     rep_phase=0 and rep_cnt reaches REPEAT_DELAY: o_held=1, rep_phase=1, rep_cnt=0, o_pulse=REPEAT_EN.
//     rep_phase=1 and rep_cnt reaches REPEAT_PERIOD: rep_cnt=0, o_pulse=REPEAT_EN.
//     s=0 -> RELEASE_WAIT, deb_cnt=1, rep_cnt frozen.
//   - RELEASE_WAIT: s=1 -> back to PRESSED; rep_cnt and rep_phase resume; no new initial pulse.
//     On the DEBOUNCE_CYCLES-th consecutive low sample -> IDLE; o_level=0 and o_held=0 in the same cycle.
//   Latency, clean edges:
//   - i_btn rise -> o_pulse/o_level rise: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//   - i_btn fall -> o_level fall: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//   o_pulse:
//   - never high two consecutive cycles, even with REPEAT_PERIOD=1: that case pulses every 2nd cycle.
//   - never asserted outside PRESSED.
//   DEBOUNCE_CYCLES=1: any single stable sample is accepted. No pulse on release.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1)
//   1 Clean press: i_btn high 8 cycles then low.
//     -> one o_pulse 6 cycles after the rise; o_level high at that cycle.
//     -> o_level low 6 cycles after the fall; o_held stays 0.
//   2 Bounce: i_btn patterns 1,1,1,0 repeated 5x, then 0.
//     -> o_pulse never high; o_level stays 0; FSM returns to IDLE.
//   3 Long hold, 40 cycles, first pulse at t0.
//     -> pulses at t0, t0+10, t0+13, t0+16, ...; o_held rises at t0+10.
//     -> o_held falls with o_level after release.
//   4 Release glitch: during hold, i_btn low 2 cycles, then high.
//     -> o_level stays 1, no extra pulse, repeat schedule shifted by exactly 2 cycles.
//     Same test with REPEAT_EN=0: no repeat pulses, o_held still rises at t0+10.
//   5 Async reset mid-hold, asserted between clock edges.
//     -> o_pulse/o_level/o_held read 0 before the next edge.
//     -> after release, with i_btn still high: new o_pulse 6 cycles later.
//   6 Integration: instance feeding the counter top; 17 clean presses -> digit reads 0x1 (0..F wrap).

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and auto-repeats a raw push-button into one-cycle press strobes.
module btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_level,
  output logic o_held
);
  localparam int M1 = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXP = M1 > REPEAT_PERIOD ? M1 : REPEAT_PERIOD;
  localparam int CW = $clog2(MAXP + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER = CW'(REPEAT_PERIOD);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] deb_cnt, rep_cnt, rep_nxt;
  logic rep_phase, rep_hit, rep_fire, s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], i_btn};
  // a repeat point landing right after a strobe is held off one cycle so strobes never touch
  always_comb begin
    rep_nxt = rep_cnt + CW'(1);
    rep_hit = rep_nxt == (rep_phase ? PER : DLY);
    rep_fire = rep_hit && !o_pulse;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      deb_cnt <= '0;
      rep_cnt <= '0;
      rep_phase <= 1'b0;
      o_pulse <= 1'b0;
      o_level <= 1'b0;
      o_held <= 1'b0;
    end else begin
      o_pulse <= 1'b0;
      case (state)
        IDLE, PRESS_WAIT:
          if (!s) begin
            state <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state <= PRESSED;
            deb_cnt <= '0;
            rep_cnt <= '0;
            rep_phase <= 1'b0;
            o_level <= 1'b1;
            o_pulse <= 1'b1;
          end else begin
            state <= PRESS_WAIT;
            deb_cnt <= deb_cnt + CW'(1);
          end
        default:
          if (!s) begin
            if (deb_cnt == DEB_LAST) begin
              state <= IDLE;
              deb_cnt <= '0;
              o_level <= 1'b0;
              o_held <= 1'b0;
            end else begin
              state <= RELEASE_WAIT;
              deb_cnt <= deb_cnt + CW'(1);
            end
          end else begin
            state <= PRESSED;
            deb_cnt <= '0;
            if (rep_fire) begin
              rep_cnt <= '0;
              rep_phase <= 1'b1;
              o_held <= 1'b1;
              o_pulse <= REPEAT_EN != 0;
            end else if (!rep_hit) rep_cnt <= rep_nxt;
          end
      endcase
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: checks two conditioners (repeat on/off) against a run-length/hold-time model each cycle.
module tb_btn_conditioner;
  localparam int DEB = 4, DLY = 10, PER = 3;
  logic clk = 0, rst = 1, i_btn = 0, dclr = 1;
  logic pulse0, level0, held0, pulse1, level1, held1;
  logic [3:0] digit;
  int total = 0, bad = 0, pcnt = 0, p0;
  bit h0, h1;
  bit m_lvl[2], e_pulse[2];
  int m_run[2], m_ht[2];
  always #5 clk = ~clk;
  btn_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER))
    u0 (.i_clk(clk), .i_reset(rst), .i_btn(i_btn), .o_pulse(pulse0), .o_level(level0), .o_held(held0));
  btn_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER))
    u1 (.i_clk(clk), .i_reset(rst), .i_btn(i_btn), .o_pulse(pulse1), .o_level(level1), .o_held(held1));
  always @(posedge clk) digit <= dclr ? 4'd0 : pulse0 ? digit + 4'd1 : digit;
  task automatic chk(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", nm, got, exp, $time);
    end
  endtask
  task automatic chki(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask
  // level flips after DEB consecutive opposite samples; repeats fall at hold time DLY, DLY+PER, ...
  task automatic model(input int m, input bit ren, input bit s);
    e_pulse[m] = 0;
    if (!m_lvl[m]) begin
      m_run[m] = s ? m_run[m] + 1 : 0;
      if (m_run[m] == DEB) begin
        m_lvl[m] = 1; m_run[m] = 0; m_ht[m] = 0; e_pulse[m] = 1;
      end
    end else if (!s) begin
      m_run[m]++;
      if (m_run[m] == DEB) begin
        m_lvl[m] = 0; m_run[m] = 0; m_ht[m] = 0;
      end
    end else begin
      m_run[m] = 0;
      m_ht[m]++;
      if (ren && m_ht[m] >= DLY && (m_ht[m] - DLY) % PER == 0) e_pulse[m] = 1;
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (rst) begin
      h0 = 0; h1 = 0;
      for (int m = 0; m < 2; m++) begin
        m_lvl[m] = 0; m_run[m] = 0; m_ht[m] = 0; e_pulse[m] = 0;
      end
    end else begin
      bit s;
      s = h1; h1 = h0; h0 = i_btn;
      model(0, 1, s);
      model(1, 0, s);
    end
    if (pulse0) pcnt++;
    chk("pulse0", pulse0, e_pulse[0]);
    chk("level0", level0, m_lvl[0]);
    chk("held0", held0, m_lvl[0] && m_ht[0] >= DLY);
    chk("pulse1", pulse1, e_pulse[1]);
    chk("level1", level1, m_lvl[1]);
    chk("held1", held1, m_lvl[1] && m_ht[1] >= DLY);
  end
  task automatic hold(input bit b, input int n);
    i_btn = b;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pulse", pulse0, 0); chk("rst_level", level0, 0); chk("rst_held", held0, 0);
    rst = 0;
    hold(0, 3);
    // clean press
    hold(1, 5); chk("t1_level_early", level0, 0);
    hold(1, 1); chk("t1_pulse", pulse0, 1); chk("t1_level", level0, 1);
    hold(1, 1); chk("t1_pulse_one", pulse0, 0);
    hold(1, 1);
    hold(0, 5); chk("t1_level_hold", level0, 1);
    hold(0, 1); chk("t1_level_fall", level0, 0); chk("t1_held", held0, 0);
    hold(0, 4);
    // bounce
    p0 = pcnt;
    for (int i = 0; i < 5; i++) begin
      hold(1, 3); hold(0, 1);
    end
    hold(0, 8); chki("t2_pulses", pcnt - p0, 0); chk("t2_level", level0, 0);
    // long hold
    p0 = pcnt;
    hold(1, 6); chk("t3_t0", pulse0, 1);
    hold(1, 9); chk("t3_held_pre", held0, 0);
    hold(1, 1); chk("t3_rep1", pulse0, 1); chk("t3_held", held0, 1);
    chk("t3_held_nr", held1, 1); chk("t3_pulse_nr", pulse1, 0);
    hold(1, 2); chk("t3_gap", pulse0, 0);
    hold(1, 1); chk("t3_rep2", pulse0, 1);
    hold(1, 21);
    hold(0, 5); chk("t3_held_rel", held0, 1);
    hold(0, 1); chk("t3_held_fall", held0, 0); chk("t3_level_fall", level0, 0);
    chki("t3_count", pcnt - p0, 10);
    hold(0, 4);
    // release glitch
    hold(1, 6); chk("t4_t0", pulse0, 1);
    hold(1, 4); hold(0, 2);
    hold(1, 5); chk("t4_level", level0, 1); chk("t4_no_rep", pulse0, 0); chk("t4_held_pre", held0, 0);
    hold(1, 1); chk("t4_rep1", pulse0, 1); chk("t4_held", held0, 1); chk("t4_held_nr", held1, 1);
    hold(1, 2); chk("t4_gap", pulse0, 0);
    hold(1, 1); chk("t4_rep2", pulse0, 1);
    hold(0, 12);
    // async reset mid-hold
    hold(1, 6); chk("t5_t0", pulse0, 1);
    hold(1, 10); chk("t5_held_pre", held0, 1);
    #2 rst = 1;
    #1 chk("t5_rst_pulse", pulse0, 0); chk("t5_rst_level", level0, 0); chk("t5_rst_held", held0, 0);
    @(negedge clk); rst = 0;
    hold(1, 5); chk("t5_pre", pulse0, 0);
    hold(1, 1); chk("t5_repress", pulse0, 1);
    hold(0, 12);
    // integration: digit counter fed by strobes
    dclr = 0;
    for (int i = 0; i < 17; i++) begin
      hold(1, 8); hold(0, 8);
    end
    chki("t6_digit", digit, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
